// File: rtl/redmule_z_packer.sv
// redmule_z_packer: captures one result tile and streams it row by row onto
// the Z store channel, masking leftover columns and skipping leftover rows.
module redmule_z_packer #(
    parameter int unsigned ARRAY_H = 4,
    parameter int unsigned ELEMS   = 16,
    parameter int unsigned ELEM_W  = 16,
    parameter int unsigned DATA_W  = ELEMS * ELEM_W,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                               clk_i,
    input  logic                               rst_i,
    input  logic                               clear_i,
    input  logic                               enable_i,
    input  logic                               tile_valid_i,
    output logic                               tile_ready_o,
    input  logic [ARRAY_H*DATA_W-1:0]          tile_data_i,
    input  logic [$clog2(ARRAY_H+1)-1:0]       rows_i,
    input  logic [$clog2(ELEMS+1)-1:0]         cols_i,
    output logic [DATA_W-1:0]                  z_data_o,
    output logic [DATA_W/8-1:0]                z_strb_o,
    output logic                               z_valid_o,
    input  logic                               z_ready_i,
    output logic                               busy_o,
    output logic [CNT_W-1:0]                   tiles_done_o
);

    localparam int unsigned ROW_W          = $clog2(ARRAY_H + 1);
    localparam int unsigned COL_W          = $clog2(ELEMS + 1);
    localparam int unsigned STRB_W         = DATA_W / 8;
    localparam int unsigned BYTES_PER_ELEM = ELEM_W / 8;
    localparam int unsigned TILE_W         = ARRAY_H * DATA_W;

    typedef enum logic {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } state_e;

    state_e                state_q,      state_d;
    logic [TILE_W-1:0]     tile_q,       tile_d;
    logic [ROW_W-1:0]      rows_eff_q,   rows_eff_d;
    logic [COL_W-1:0]      cols_eff_q,   cols_eff_d;
    logic [ROW_W-1:0]      row_cnt_q,    row_cnt_d;
    logic [CNT_W-1:0]      tiles_done_q, tiles_done_d;
    logic [DATA_W-1:0]     z_data_q,     z_data_d;
    logic [STRB_W-1:0]     z_strb_q,     z_strb_d;
    logic                  z_valid_q,    z_valid_d;
    logic                  busy_q,       busy_d;

    logic                  last_beat;
    logic                  beat_fire;
    logic                  accept;
    logic [ROW_W-1:0]      rows_in_eff;
    logic [COL_W-1:0]      cols_in_eff;

    // Select one row out of a packed tile.
    function automatic logic [DATA_W-1:0] get_row(input logic [TILE_W-1:0] tile,
                                                  input logic [ROW_W-1:0]  idx);
        logic [DATA_W-1:0] res;
        res = '0;
        for (int unsigned r = 0; r < ARRAY_H; r++) begin
            if (ROW_W'(r) == idx) begin
                res = tile[r*DATA_W +: DATA_W];
            end
        end
        return res;
    endfunction

    // Zero the elements at or beyond the valid column count.
    function automatic logic [DATA_W-1:0] mask_row(input logic [DATA_W-1:0] row,
                                                   input logic [COL_W-1:0]  cols);
        logic [DATA_W-1:0] res;
        res = '0;
        for (int unsigned j = 0; j < ELEMS; j++) begin
            if (j < 32'(cols)) begin
                res[j*ELEM_W +: ELEM_W] = row[j*ELEM_W +: ELEM_W];
            end
        end
        return res;
    endfunction

    // Byte strobes covering the valid columns only.
    function automatic logic [STRB_W-1:0] make_strb(input logic [COL_W-1:0] cols);
        logic [STRB_W-1:0] res;
        res = '0;
        for (int unsigned b = 0; b < STRB_W; b++) begin
            res[b] = (b < 32'(cols) * BYTES_PER_ELEM);
        end
        return res;
    endfunction

    // Handshake qualifiers and input clamping.
    always_comb begin
        last_beat    = (state_q == DRAIN) && (row_cnt_q == rows_eff_q - ROW_W'(1));
        beat_fire    = (state_q == DRAIN) && z_ready_i;
        tile_ready_o = enable_i && ((state_q == IDLE) || (last_beat && z_ready_i));
        accept       = tile_valid_i && tile_ready_o;
        rows_in_eff  = (rows_i > ROW_W'(ARRAY_H)) ? ROW_W'(ARRAY_H) : rows_i;
        cols_in_eff  = (cols_i > COL_W'(ELEMS))   ? COL_W'(ELEMS)   : cols_i;
    end

    // Next-state and next-output computation.
    always_comb begin
        state_d      = state_q;
        tile_d       = tile_q;
        rows_eff_d   = rows_eff_q;
        cols_eff_d   = cols_eff_q;
        row_cnt_d    = row_cnt_q;
        tiles_done_d = tiles_done_q;
        z_data_d     = z_data_q;
        z_strb_d     = z_strb_q;

        if (beat_fire) begin
            if (last_beat) begin
                tiles_done_d = tiles_done_d + CNT_W'(1);
                state_d      = IDLE;
                z_data_d     = '0;
                z_strb_d     = '0;
            end else begin
                row_cnt_d = row_cnt_q + ROW_W'(1);
                z_data_d  = mask_row(get_row(tile_q, row_cnt_q + ROW_W'(1)), cols_eff_q);
            end
        end

        if (accept) begin
            tile_d     = tile_data_i;
            rows_eff_d = rows_in_eff;
            cols_eff_d = cols_in_eff;
            row_cnt_d  = '0;
            if ((rows_in_eff == '0) || (cols_in_eff == '0)) begin
                // Degenerate tile completes immediately without beats.
                tiles_done_d = tiles_done_d + CNT_W'(1);
                state_d      = IDLE;
                z_data_d     = '0;
                z_strb_d     = '0;
            end else begin
                state_d  = DRAIN;
                z_data_d = mask_row(get_row(tile_data_i, '0), cols_in_eff);
                z_strb_d = make_strb(cols_in_eff);
            end
        end

        z_valid_d = (state_d == DRAIN);
        busy_d    = (state_d == DRAIN);
    end

    // State and output registers; reset and clear discard everything.
    always_ff @(posedge clk_i) begin
        if (rst_i || clear_i) begin
            state_q      <= IDLE;
            tile_q       <= '0;
            rows_eff_q   <= '0;
            cols_eff_q   <= '0;
            row_cnt_q    <= '0;
            tiles_done_q <= '0;
            z_data_q     <= '0;
            z_strb_q     <= '0;
            z_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            tile_q       <= tile_d;
            rows_eff_q   <= rows_eff_d;
            cols_eff_q   <= cols_eff_d;
            row_cnt_q    <= row_cnt_d;
            tiles_done_q <= tiles_done_d;
            z_data_q     <= z_data_d;
            z_strb_q     <= z_strb_d;
            z_valid_q    <= z_valid_d;
            busy_q       <= busy_d;
        end
    end

    assign z_data_o     = z_data_q;
    assign z_strb_o     = z_strb_q;
    assign z_valid_o    = z_valid_q;
    assign busy_o       = busy_q;
    assign tiles_done_o = tiles_done_q;

endmodule

// File: tb/tb_redmule_z_packer.sv
// Bench for redmule_z_packer: beat-queue reference model checked every cycle.
module tb_redmule_z_packer;

    localparam int unsigned AH = 4;
    localparam int unsigned NE = 16;
    localparam int unsigned EW = 16;
    localparam int unsigned DW = NE * EW;
    localparam int unsigned TW = AH * DW;

    logic           clk_i;
    logic           rst_i;
    logic           clear_i;
    logic           enable_i;
    logic           tile_valid_i;
    logic           tile_ready_o;
    logic [TW-1:0]  tile_data_i;
    logic [2:0]     rows_i;
    logic [4:0]     cols_i;
    logic [DW-1:0]  z_data_o;
    logic [DW/8-1:0] z_strb_o;
    logic           z_valid_o;
    logic           z_ready_i;
    logic           busy_o;
    logic [15:0]    tiles_done_o;

    redmule_z_packer dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clear_i      (clear_i),
        .enable_i     (enable_i),
        .tile_valid_i (tile_valid_i),
        .tile_ready_o (tile_ready_o),
        .tile_data_i  (tile_data_i),
        .rows_i       (rows_i),
        .cols_i       (cols_i),
        .z_data_o     (z_data_o),
        .z_strb_o     (z_strb_o),
        .z_valid_o    (z_valid_o),
        .z_ready_i    (z_ready_i),
        .busy_o       (busy_o),
        .tiles_done_o (tiles_done_o)
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    int checks   = 0;
    int failures = 0;

    // Tiles waiting to be offered to the DUT.
    logic [TW-1:0] pd_q[$];
    logic [2:0]    pr_q[$];
    logic [4:0]    pc_q[$];

    // Reference model: remaining beats of the tile in flight, completed count.
    logic [DW-1:0]   eq_d[$];
    logic [DW/8-1:0] eq_s[$];
    logic [15:0]     m_done = 16'd0;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        assert (act === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, act, exp);
        end
    endtask

    function automatic logic [TW-1:0] pattern_tile();
        logic [TW-1:0] t;
        t = '0;
        for (int r = 0; r < int'(AH); r++)
            for (int j = 0; j < int'(NE); j++)
                t[r*DW + j*EW +: EW] = {4'h0, 4'(r), 4'h0, 4'(j)};
        return t;
    endfunction

    function automatic logic [TW-1:0] random_tile();
        logic [TW-1:0] t;
        for (int w = 0; w < int'(TW / 32); w++) t[w*32 +: 32] = $urandom;
        return t;
    endfunction

    task automatic push_tile(input logic [TW-1:0] t, input logic [2:0] r, input logic [4:0] c);
        pd_q.push_back(t);
        pr_q.push_back(r);
        pc_q.push_back(c);
    endtask

    // One clock cycle: drive, check against model, advance model.
    task automatic step(input bit v_in, input bit zr, input bit en, input bit clr);
        bit v;
        bit exp_valid;
        bit exp_ready;
        bit acc;
        int nr;
        int nc;
        logic [TW-1:0] t;
        logic [DW-1:0] row;
        logic [DW/8-1:0] st;
        v = v_in && (pd_q.size() > 0);
        @(negedge clk_i);
        tile_valid_i = v;
        if (v) begin
            tile_data_i = pd_q[0];
            rows_i      = pr_q[0];
            cols_i      = pc_q[0];
        end else begin
            tile_data_i = random_tile();
            rows_i      = 3'($urandom);
            cols_i      = 5'($urandom);
        end
        z_ready_i = zr;
        enable_i  = en;
        clear_i   = clr;
        #1;
        exp_valid = (eq_d.size() > 0);
        exp_ready = en && ((eq_d.size() == 0) || ((eq_d.size() == 1) && zr));
        chk("tile_ready", DW'(tile_ready_o), DW'(exp_ready));
        chk("z_valid", DW'(z_valid_o), DW'(exp_valid));
        chk("busy", DW'(busy_o), DW'(exp_valid));
        chk("z_data", z_data_o, exp_valid ? eq_d[0] : '0);
        chk("z_strb", DW'(z_strb_o), exp_valid ? DW'(eq_s[0]) : '0);
        chk("tiles_done", DW'(tiles_done_o), DW'(m_done));
        acc = v && exp_ready;
        if (clr) begin
            eq_d.delete();
            eq_s.delete();
            m_done = 16'd0;
        end else begin
            if (exp_valid && zr) begin
                void'(eq_d.pop_front());
                void'(eq_s.pop_front());
                if (eq_d.size() == 0) m_done++;
            end
            if (acc) begin
                t  = pd_q[0];
                nr = (int'(pr_q[0]) < int'(AH)) ? int'(pr_q[0]) : int'(AH);
                nc = (int'(pc_q[0]) < int'(NE)) ? int'(pc_q[0]) : int'(NE);
                if (nr == 0 || nc == 0) begin
                    m_done++;
                end else begin
                    st = '0;
                    for (int b = 0; b < nc * int'(EW / 8); b++) st[b] = 1'b1;
                    for (int r = 0; r < nr; r++) begin
                        row = '0;
                        for (int j = 0; j < nc; j++) row[j*EW +: EW] = t[r*DW + j*EW +: EW];
                        eq_d.push_back(row);
                        eq_s.push_back(st);
                    end
                end
            end
        end
        if (acc) begin
            void'(pd_q.pop_front());
            void'(pr_q.pop_front());
            void'(pc_q.pop_front());
        end
    endtask

    // Keep stepping until all pending tiles are drained, bounded by a cycle budget.
    task automatic run_until_idle(input int budget, input bit rnd);
        int k;
        bit busy;
        k = 0;
        while (k < budget && (pd_q.size() > 0 || eq_d.size() > 0)) begin
            if (rnd)
                step(($urandom % 4) != 0, ($urandom % 3) != 0, ($urandom % 5) != 0, 1'b0);
            else
                step(1'b1, 1'b1, 1'b1, 1'b0);
            k++;
        end
        busy = (pd_q.size() > 0 || eq_d.size() > 0);
        chk("drain_timeout", DW'(busy), DW'(0));
    endtask

    initial begin
        rst_i        = 1'b1;
        clear_i      = 1'b0;
        enable_i     = 1'b0;
        tile_valid_i = 1'b0;
        z_ready_i    = 1'b0;
        tile_data_i  = '0;
        rows_i       = '0;
        cols_i       = '0;
        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;

        // Reset state
        step(1'b0, 1'b0, 1'b0, 1'b0);

        // Full tile, no backpressure
        push_tile(pattern_tile(), 3'd4, 5'd16);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("full_done", DW'(tiles_done_o), DW'(16'd1));

        // Partial tile with column masking
        push_tile(random_tile(), 3'd3, 5'd5);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        chk("partial_strb", DW'(z_strb_o), DW'(32'h0000_03FF));
        chk("partial_hi", z_data_o >> 80, '0);
        run_until_idle(20, 1'b0);

        // Backpressure on beat 1
        push_tile(pattern_tile(), 3'd4, 5'd16);
        push_tile(random_tile(), 3'd2, 5'd9);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        repeat (3) step(1'b1, 1'b0, 1'b1, 1'b0);
        run_until_idle(20, 1'b0);

        // Back-to-back tiles with valid held high
        push_tile(random_tile(), 3'd4, 5'd16);
        push_tile(random_tile(), 3'd4, 5'd16);
        run_until_idle(20, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("b2b_done", DW'(tiles_done_o), DW'(16'd6));

        // Degenerate and clamped tiles, including a degenerate one right after a last beat
        push_tile(random_tile(), 3'd0, 5'd16);
        push_tile(random_tile(), 3'd4, 5'd0);
        push_tile(random_tile(), 3'd7, 5'd20);
        push_tile(random_tile(), 3'd0, 5'd3);
        push_tile(random_tile(), 3'd5, 5'd31);
        run_until_idle(40, 1'b0);

        // Clear during beat 2, then a normal tile
        push_tile(pattern_tile(), 3'd4, 5'd16);
        step(1'b1, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("clear_valid", DW'(z_valid_o), DW'(0));
        chk("clear_done", DW'(tiles_done_o), DW'(0));
        push_tile(random_tile(), 3'd4, 5'd12);
        run_until_idle(20, 1'b0);

        // Randomised traffic
        for (int i = 0; i < 60; i++)
            push_tile(random_tile(), 3'($urandom_range(0, 7)), 5'($urandom_range(0, 20)));
        run_until_idle(3000, 1'b1);

        // Counter wrap via degenerate tiles
        step(1'b0, 1'b1, 1'b1, 1'b1);
        for (int i = 0; i < 65535; i++) begin
            push_tile('0, 3'd0, 5'd4);
            step(1'b1, 1'b1, 1'b1, 1'b0);
        end
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("wrap_max", DW'(tiles_done_o), DW'(16'hFFFF));
        push_tile(random_tile(), 3'd1, 5'd1);
        run_until_idle(10, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0);
        chk("wrap_zero", DW'(tiles_done_o), DW'(16'h0000));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/redmule_z_packer.md
Name: redmule_z_packer

Overview:
- Output staging stage directly upstream of the streamer's Z store channel.
- Captures one engine result tile of ARRAY_H rows in a single handshake and serialises it row by row onto the Z stream, one row per beat.
- Drives per-beat byte strobes so that leftover columns (partial tile width) are masked.
- Skips leftover rows (partial tile height); those rows emit no beats.

Parameters:
- ARRAY_H, 4: number of rows in a result tile.
- ELEMS, 16: elements per row.
- ELEM_W, 16: element width in bits; must be a multiple of 8.
- DATA_W, ELEMS*ELEM_W (256): Z stream data width.
- CNT_W, 16: width of the completed-tile counter.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, synchronous, active-high.
- clear_i  in  1  synchronous soft clear, same effect as rst_i.
- enable_i  in  1  gates acceptance of new tiles only.
- tile_valid_i  in  1  engine tile valid.
- tile_ready_o  out  1  packer ready for a tile.
- tile_data_i  in  ARRAY_H*DATA_W  row r at bits [r*DATA_W +: DATA_W]; element j of a row at [j*ELEM_W +: ELEM_W].
- rows_i  in  $clog2(ARRAY_H+1)  valid rows in the tile.
- cols_i  in  $clog2(ELEMS+1)  valid elements per row.
- z_data_o  out  DATA_W  stream data to the Z sink.
- z_strb_o  out  DATA_W/8  byte strobes.
- z_valid_o  out  1  stream valid.
- z_ready_i  in  1  stream ready.
- busy_o  out  1  high while in DRAIN.
- tiles_done_o  out  CNT_W  number of completed tiles; wraps.

Behaviour:
- FSM states: IDLE, DRAIN.
- Reset or clear (priority over everything):
  - state returns to IDLE; row_cnt = 0; tiles_done_o = 0.
  - z_valid_o, z_data_o, z_strb_o, busy_o = 0.
  - Any buffered tile is discarded.
- Tile handshake completes when tile_valid_i && tile_ready_o.
- tile_ready_o:
  - IDLE: tile_ready_o = enable_i.
  - DRAIN: tile_ready_o = enable_i && last beat && z_ready_i (combinational path from z_ready_i, allows back-to-back tiles).
- On accept:
  - Latch tile_data_i, rows_eff = min(rows_i, ARRAY_H), cols_eff = min(cols_i, ELEMS).
  - row_cnt = 0.
  - Next state DRAIN; first beat valid the cycle after accept (latency 1).
- Degenerate tile (rows_eff == 0 or cols_eff == 0):
  - Accepted, zero beats emitted.
  - tiles_done_o increments the next cycle; state stays or returns to IDLE.
- DRAIN outputs:
  - z_valid_o = 1.
  - z_data_o = latched row[row_cnt], with elements j >= cols_eff forced to 0.
  - z_strb_o bit b = 1 iff b < cols_eff*ELEM_W/8.
  - z_data_o and z_strb_o stay stable while z_valid_o && !z_ready_i.
- Beat handshake (z_valid_o && z_ready_i):
  - Not last beat: row_cnt increments.
  - Last beat (row_cnt == rows_eff-1): tiles_done_o increments.
    - If a new tile is accepted in the same cycle: remain in DRAIN with row_cnt = 0 and the new tile latched; no bubble.
    - Otherwise: go to IDLE; z_valid_o = 0 next cycle.
- enable_i low during DRAIN:
  - The current tile finishes draining.
  - No new tile is accepted.
- tiles_done_o wraps from 2^CNT_W-1 to 0.
- busy_o = (state == DRAIN).
- IDLE: z_data_o and z_strb_o are driven 0.
- Input data outside the captured cycle is ignored.

Test Plan:
- Full tile, rows_i=4, cols_i=16, z_ready_i=1, row r elements = 16'h0r0j:
  - 4 beats on consecutive cycles starting 1 cycle after accept, strb all 1s.
  - tiles_done_o 0 -> 1; busy_o high 4 cycles.
- Partial tile, rows_i=3, cols_i=5:
  - 3 beats; z_strb_o = 32'h0000_03FF; bits [255:80] of z_data_o = 0.
- Backpressure, z_ready_i low for 3 cycles on beat 1:
  - z_data_o/z_strb_o held stable; beat order 0,1,2,3 preserved.
  - tile_ready_o low until the last-beat handshake.
- Back-to-back tiles, tile_valid_i held high with two tiles:
  - 8 beats with no idle cycle between tiles; tiles_done_o = 2.
- Degenerate and clamp cases:
  - rows_i=0: accepted, no beats, tiles_done_o +1.
  - rows_i=7 (if representable) / cols_i=20: clamped to 4 rows, 16 columns.
- Clear and counter wrap:
  - clear_i asserted on beat 2 -> next cycle z_valid_o=0, IDLE, tiles_done_o=0.
  - Subsequent tile drains normally.
  - With tiles_done_o preloaded to 16'hFFFF via 65535 degenerate tiles, one more tile -> 0.
